sys_ctrl_rx_cmd: RTL and testbench

Parametrised receive-side command decoder for the system controller. It consumes byte frames from the UART receiver and issues register-file writes and reads, burst writes, and ALU operations. It also provides per-frame timeout recovery and a protocol error flag. All outputs are registered and sit between the RX data synchroniser and the register file / ALU / clock-gating cell.

---
 rtl/sys_ctrl_rx_cmd.sv | 230 +++++++++++++++++++++++
 tb/tb_sys_ctrl_rx_cmd.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_rx_cmd.sv
// Receive-side command decoder: turns UART byte frames into register-file
// writes/reads, burst writes and ALU starts, with per-frame timeout recovery.
module sys_ctrl_rx_cmd #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int OPA_ADDR   = 0,
  parameter int OPB_ADDR   = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CLK_EN,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  BUSY,
  output logic                  CMD_ERR
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADD   = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADD   = 4'd3;
  localparam logic [3:0] ALU_OPA  = 4'd4;
  localparam logic [3:0] ALU_OPB  = 4'd5;
  localparam logic [3:0] ALU_FUNC = 4'd6;
  localparam logic [3:0] ALU_NOP  = 4'd7;
  localparam logic [3:0] BW_ADD   = 4'd8;
  localparam logic [3:0] BW_CNT   = 4'd9;
  localparam logic [3:0] BW_DATA  = 4'd10;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  alu_en_q, alu_en_d;
  logic                  err_q, err_d;
  logic                  clk_en_q, clk_en_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;

  logic                  cmd_hi_zero;
  logic                  addr_bad;
  logic                  timeout_hit;
  logic [7:0]            cmd_byte;
  logic [ADDR_WIDTH-1:0] frame_addr;

  assign cmd_byte    = RX_P_DATA[7:0];
  assign cmd_hi_zero = ((RX_P_DATA >> 8) == '0);
  assign addr_bad    = ((RX_P_DATA >> ADDR_WIDTH) != '0);
  assign frame_addr  = RX_P_DATA[ADDR_WIDTH-1:0];

  // Counter sits at TIMEOUT for one cycle; a frame arriving then still wins.
  assign timeout_hit = (TIMEOUT != 0) && (state_q != IDLE) && !RX_D_VLD &&
                       (tmo_q == TW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    tmo_d     = tmo_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    err_d     = 1'b0;
    address_d = address_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;

    if (state_q == IDLE || RX_D_VLD) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT)) begin
      tmo_d = tmo_q + TW'(1);
    end

    if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else if (RX_D_VLD) begin
      case (state_q)
        IDLE: begin
          if (!cmd_hi_zero) begin
            err_d = 1'b1;
          end else begin
            case (cmd_byte)
              8'hAA:   state_d = WR_ADD;
              8'hBB:   state_d = RD_ADD;
              8'hCC:   state_d = ALU_OPA;
              8'hDD:   state_d = ALU_NOP;
              8'hEE:   state_d = BW_ADD;
              default: err_d   = 1'b1;
            endcase
          end
        end
        WR_ADD: begin
          if (addr_bad) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = frame_addr;
            state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_data_d = RX_P_DATA;
          state_d   = IDLE;
        end
        RD_ADD: begin
          if (addr_bad) begin
            err_d = 1'b1;
          end else begin
            rd_en_d   = 1'b1;
            address_d = frame_addr;
          end
          state_d = IDLE;
        end
        ALU_OPA: begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(OPA_ADDR);
          wr_data_d = RX_P_DATA;
          state_d   = ALU_OPB;
        end
        ALU_OPB: begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(OPB_ADDR);
          wr_data_d = RX_P_DATA;
          state_d   = ALU_FUNC;
        end
        ALU_FUNC, ALU_NOP: begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          state_d   = IDLE;
        end
        BW_ADD: begin
          if (addr_bad) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = frame_addr;
            state_d = BW_CNT;
          end
        end
        BW_CNT: begin
          if (RX_P_DATA == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            bcnt_d  = RX_P_DATA;
            state_d = BW_DATA;
          end
        end
        BW_DATA: begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_data_d = RX_P_DATA;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          if (bcnt_q == DATA_WIDTH'(1)) begin
            bcnt_d  = '0;
            state_d = IDLE;
          end else begin
            bcnt_d = bcnt_q - DATA_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Gate enable tracks the next state so it is registered alongside the FSM.
  assign clk_en_d = (state_d == ALU_FUNC) || (state_d == ALU_NOP) || alu_en_d;
  assign busy_d   = (state_d != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      bcnt_q    <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      err_q     <= 1'b0;
      clk_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      address_q <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      err_q     <= err_d;
      clk_en_q  <= clk_en_d;
      busy_q    <= busy_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
    end
  end

  assign ALU_EN  = alu_en_q;
  assign ALU_FUN = alu_fun_q;
  assign CLK_EN  = clk_en_q;
  assign Address = address_q;
  assign WrEn    = wr_en_q;
  assign RdEn    = rd_en_q;
  assign WrData  = wr_data_q;
  assign BUSY    = busy_q;
  assign CMD_ERR = err_q;

endmodule

// File: tb/tb_sys_ctrl_rx_cmd.sv
// Directed bench for sys_ctrl_rx_cmd: frames are driven 1 time unit after each
// rising edge, and outputs checked at that same point reflect the edge just taken.
module tb_sys_ctrl_rx_cmd;

  localparam int TMO = 8;

  logic       CLK;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_EN;
  logic [3:0] Address;
  logic       WrEn;
  logic       RdEn;
  logic [7:0] WrData;
  logic       BUSY;
  logic       CMD_ERR;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0;
  int wr_base, rd_base, err_base, alu_base;

  sys_ctrl_rx_cmd #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4),
    .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .Address(Address),
    .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe counters sampled on the falling edge.
  always @(negedge CLK) begin
    if (WrEn)    wr_cnt  <= wr_cnt + 1;
    if (RdEn)    rd_cnt  <= rd_cnt + 1;
    if (ALU_EN)  alu_cnt <= alu_cnt + 1;
    if (CMD_ERR) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("check %s ok val=%0h", tag, got);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(posedge CLK);
    #1;
    RX_D_VLD  = v;
    RX_P_DATA = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    RX_D_VLD = 1'b0;
    RX_P_DATA = 8'h00;
    #1;
    chk("rst_strobes", {28'd0, WrEn, RdEn, ALU_EN, CMD_ERR}, 32'd0);
    chk("rst_busy_clken", {30'd0, BUSY, CLK_EN}, 32'd0);
    chk("rst_buses", {16'd0, Address, WrData, ALU_FUN}, 32'd0);
    step(0, 8'h00);
    step(0, 8'h00);
    RST = 1'b1;

    // Reset mid-burst after 2 of 5 writes
    step(1, 8'hEE); step(1, 8'h02); step(1, 8'h05);
    step(1, 8'hA0); step(1, 8'hA1);
    step(0, 8'h00);
    chk("mid_burst_wr2", {19'd0, WrEn, Address, WrData}, {19'd0, 1'b1, 4'h3, 8'hA1});
    chk("mid_burst_busy", {31'd0, BUSY}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_strobes", {27'd0, WrEn, RdEn, ALU_EN, CMD_ERR, CLK_EN}, 32'd0);
    chk("async_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("async_rst_buses", {16'd0, Address, WrData, ALU_FUN}, 32'd0);
    step(0, 8'h00);
    RST = 1'b1;
    step(0, 8'h00);
    wr_base = wr_cnt;
    step(1, 8'hAA); step(1, 8'h05); step(1, 8'h3C);
    step(0, 8'h00);
    chk("wr_after_rst", {19'd0, WrEn, Address, WrData}, {19'd0, 1'b1, 4'h5, 8'h3C});
    step(0, 8'h00);
    chk("wr_after_rst_end", {31'd0, WrEn}, 32'd0);
    step(0, 8'h00);
    chk("wr_after_rst_count", wr_cnt - wr_base, 32'd1);

    // ALU with operands
    step(1, 8'hCC);
    step(1, 8'h12);
    chk("alu_busy", {30'd0, BUSY, WrEn}, 32'b10);
    step(1, 8'h34);
    chk("alu_opa_wr", {18'd0, CLK_EN, WrEn, Address, WrData}, {18'd0, 1'b0, 1'b1, 4'h0, 8'h12});
    step(1, 8'h03);
    chk("alu_opb_wr", {18'd0, CLK_EN, WrEn, Address, WrData}, {18'd0, 1'b1, 1'b1, 4'h1, 8'h34});
    step(0, 8'h00);
    chk("alu_en", {25'd0, ALU_EN, CLK_EN, BUSY, ALU_FUN}, {25'd0, 1'b1, 1'b1, 1'b0, 4'h3});
    step(0, 8'h00);
    chk("alu_clken_fall", {30'd0, ALU_EN, CLK_EN}, 32'd0);

    // Burst with address wrap, back-to-back
    wr_base = wr_cnt;
    step(1, 8'hEE); step(1, 8'h0E); step(1, 8'h03); step(1, 8'hA1);
    step(1, 8'hA2);
    chk("bw_wr1", {19'd0, WrEn, Address, WrData}, {19'd0, 1'b1, 4'hE, 8'hA1});
    step(1, 8'hA3);
    chk("bw_wr2", {19'd0, WrEn, Address, WrData}, {19'd0, 1'b1, 4'hF, 8'hA2});
    step(0, 8'h00);
    chk("bw_wr3_wrap", {18'd0, BUSY, WrEn, Address, WrData}, {18'd0, 1'b0, 1'b1, 4'h0, 8'hA3});
    step(0, 8'h00);
    chk("bw_done", {30'd0, WrEn, BUSY}, 32'd0);
    chk("bw_count", wr_cnt - wr_base, 32'd3);

    // Read timeout
    rd_base = rd_cnt;
    err_base = err_cnt;
    step(1, 8'hBB);
    for (int i = 0; i < TMO + 1; i++) step(0, 8'h00);
    chk("tmo_pre", {30'd0, BUSY, CMD_ERR}, 32'b10);
    step(0, 8'h00);
    chk("tmo_err", {29'd0, CMD_ERR, BUSY, RdEn}, 32'b100);
    step(0, 8'h00);
    chk("tmo_err_end", {31'd0, CMD_ERR}, 32'd0);
    step(0, 8'h00);
    chk("tmo_err_count", err_cnt - err_base, 32'd1);
    chk("tmo_rd_count", rd_cnt - rd_base, 32'd0);

    // Frame exactly at expiry wins
    err_base = err_cnt;
    step(1, 8'hBB);
    for (int i = 0; i < TMO; i++) step(0, 8'h00);
    step(1, 8'h07);
    step(0, 8'h00);
    chk("tmo_frame_wins", {25'd0, RdEn, CMD_ERR, BUSY, Address}, {25'd0, 1'b1, 1'b0, 1'b0, 4'h7});
    step(0, 8'h00);
    step(0, 8'h00);
    chk("tmo_frame_no_err", err_cnt - err_base, 32'd0);

    // Protocol errors
    wr_base = wr_cnt;
    step(1, 8'h55);
    step(0, 8'h00);
    chk("bad_cmd", {29'd0, CMD_ERR, WrEn, BUSY}, 32'b100);
    step(1, 8'hAA); step(1, 8'h20);
    step(0, 8'h00);
    chk("bad_addr", {29'd0, CMD_ERR, WrEn, BUSY}, 32'b100);
    step(1, 8'hEE); step(1, 8'h04); step(1, 8'h00);
    step(0, 8'h00);
    chk("bw_zero_cnt", {29'd0, CMD_ERR, WrEn, BUSY}, 32'b100);
    step(0, 8'h00);
    chk("err_no_wr", wr_cnt - wr_base, 32'd0);

    // ALU without operands
    wr_base = wr_cnt;
    alu_base = alu_cnt;
    step(1, 8'hDD);
    step(1, 8'h07);
    chk("nop_clken", {30'd0, CLK_EN, BUSY}, 32'b11);
    step(0, 8'h00);
    chk("nop_alu_en", {26'd0, ALU_EN, CLK_EN, ALU_FUN}, {26'd0, 1'b1, 1'b1, 4'h7});
    step(0, 8'h00);
    chk("nop_clken_fall", {30'd0, ALU_EN, CLK_EN}, 32'd0);
    step(0, 8'h00);
    chk("nop_no_wr", wr_cnt - wr_base, 32'd0);
    chk("nop_alu_count", alu_cnt - alu_base, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
